store_bmp: RTL and testbench

- Write-back counterpart of the BMP loader: after processing, streams the finished image (54-byte header plus pixel bytes) out of the working RAM as an ordered byte stream.
- The stream goes to the output sink, either the testbench file writer or a downstream block.
- Reads the RAM one byte per address, absorbs the RAM's 1-cycle read latency, and honours valid/ready backpressure without losing or duplicating bytes.

---
 rtl/store_bmp_if.sv | 35 +++
 rtl/store_bmp.sv | 120 ++++++++++++
 tb/tb_store_bmp.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/store_bmp_if.sv
// store_bmp_if: bundles the control, RAM read port and output stream of store_bmp.
//   start      dump request (driven by the controller side)
//   RAM_ren    RAM read enable
//   RAM_addr   RAM read address
//   RAM_out    RAM read data, valid the cycle after RAM_ren
//   out_data   streamed byte
//   out_valid  out_data holds a valid byte
//   out_ready  sink accepts the byte
//   busy       dump in progress
//   done       one-cycle pulse after the final transfer
// master: the store_bmp side; slave: the RAM/sink/controller side.
interface store_bmp_if #(
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 18
);
  logic                  start;
  logic                  RAM_ren;
  logic [ADDR_WIDTH-1:0] RAM_addr;
  logic [BYTE_WIDTH-1:0] RAM_out;
  logic [BYTE_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, RAM_out, out_ready,
    output RAM_ren, RAM_addr, out_data, out_valid, busy, done
  );

  modport slave (
    output start, RAM_out, out_ready,
    input  RAM_ren, RAM_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/store_bmp.sv
// store_bmp: streams TOTAL_SIZE bytes out of the working RAM (addresses
// 0..TOTAL_SIZE-1, ascending) as a valid/ready byte stream.
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   store_bmp_if.master: start, RAM read port, output stream, busy/done
//
// state  | meaning
// IDLE   | waiting for start
// RUN    | issuing RAM reads (credit-limited) and streaming bytes
// DRAIN  | all reads issued; emptying the buffer
// FINISH | last byte transferred; done pulse, back to IDLE
module store_bmp #(
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 18,
  parameter int TOTAL_SIZE = 196662
) (
  input  logic       clk,
  input  logic       rst,
  store_bmp_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(TOTAL_SIZE - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] xfer_cnt_q;
  logic                  inflight_q;
  logic [BYTE_WIDTH-1:0] head_q, tail_q;
  logic                  head_v_q, tail_v_q;

  logic       ren;
  logic       pop;
  logic       last_read;
  logic       last_xfer;
  logic [2:0] used;

  // Bytes already claimed: buffered plus the read still in flight. A read is
  // allowed only if it still fits in the 2-entry buffer after this cycle's pop.
  always_comb begin
    pop       = head_v_q & bus.out_ready;
    used      = {2'b0, head_v_q} + {2'b0, tail_v_q} + {2'b0, inflight_q};
    ren       = (state_q == RUN) && (used < (3'd2 + {2'b0, pop}));
    last_read = ren && (addr_q == LAST);
    last_xfer = pop && (xfer_cnt_q == LAST);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_read) state_d = DRAIN;
      DRAIN:   if (last_xfer) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Address holds on the last read so it reads back as TOTAL_SIZE-1 until FINISH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      xfer_cnt_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= ren;
      if (state_q == FINISH) begin
        addr_q     <= '0;
        xfer_cnt_q <= '0;
      end else begin
        if (ren && !last_read) addr_q <= addr_q + ADDR_WIDTH'(1);
        if (pop) xfer_cnt_q <= xfer_cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Two-entry buffer as head/tail registers; head drives out_data directly so
  // the byte is stable during stalls and keeps its last value when empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q   <= '0;
      tail_q   <= '0;
      head_v_q <= 1'b0;
      tail_v_q <= 1'b0;
    end else if (pop) begin
      if (tail_v_q) begin
        head_q <= tail_q;
        if (inflight_q) tail_q   <= bus.RAM_out;
        else            tail_v_q <= 1'b0;
      end else if (inflight_q) begin
        head_q <= bus.RAM_out;
      end else begin
        head_v_q <= 1'b0;
      end
    end else if (inflight_q) begin
      if (!head_v_q) begin
        head_q   <= bus.RAM_out;
        head_v_q <= 1'b1;
      end else begin
        tail_q   <= bus.RAM_out;
        tail_v_q <= 1'b1;
      end
    end
  end

  assign bus.RAM_ren   = ren;
  assign bus.RAM_addr  = addr_q;
  assign bus.out_data  = head_q;
  assign bus.out_valid = head_v_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == FINISH);

endmodule

// File: tb/tb_store_bmp.sv
// tb_store_bmp: scoreboard bench for store_bmp. Instance A dumps 8 bytes,
// instance B dumps a single byte. Expected bytes are queued when a start is
// issued to an idle DUT; a monitor pops and compares on every transfer.
module tb_store_bmp;
  localparam int BW = 8;
  localparam int AW = 18;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  store_bmp_if #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus_a ();
  store_bmp_if #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW)) bus_b ();

  store_bmp #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW), .TOTAL_SIZE(N)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a.master));
  store_bmp #(.BYTE_WIDTH(BW), .ADDR_WIDTH(AW), .TOTAL_SIZE(1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b.master));

  logic [BW-1:0] ram_a [N];
  logic [BW-1:0] ram_b;

  always @(posedge clk) if (bus_a.RAM_ren) bus_a.RAM_out <= ram_a[bus_a.RAM_addr[2:0]];
  always @(posedge clk) if (bus_b.RAM_ren) bus_b.RAM_out <= ram_b;

  int errors = 0;
  int checks = 0;

  logic [BW-1:0] exp_q[$];
  int issued_a = 0, xfer_a = 0, done_cnt_a = 0;
  int ren_b = 0, xfer_b = 0, done_b = 0;
  bit stall_valid = 0;
  logic [BW-1:0] stall_data;
  int ready_mode = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // out_ready driver: 0 always ready, 1 pattern 1,0,0, 2 random, 3 never ready
  initial begin
    int pat = 0;
    bus_a.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus_a.out_ready = 1'b1;
        1: begin bus_a.out_ready = (pat == 0); pat = (pat + 1) % 3; end
        2: bus_a.out_ready = 1'($urandom_range(0, 1));
        default: bus_a.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus_a.RAM_ren) begin
          check("ren_addr", int'(bus_a.RAM_addr), issued_a);
          check("ren_credit",
                int'((issued_a - xfer_a - ((bus_a.out_valid && bus_a.out_ready) ? 1 : 0)) < 2), 1);
          issued_a++;
        end
        if (bus_a.out_valid) begin
          if (stall_valid) check("stall_stable", int'(bus_a.out_data), int'(stall_data));
          if (bus_a.out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra_byte: got 0x%0h expected no transfer at %0t", bus_a.out_data, $time);
            end else begin
              check("data", int'(bus_a.out_data), int'(exp_q.pop_front()));
            end
            xfer_a++;
            stall_valid = 0;
          end else begin
            stall_valid = 1;
            stall_data  = bus_a.out_data;
          end
        end else begin
          stall_valid = 0;
        end
        if (bus_a.done) begin
          check("done_after_last", exp_q.size(), 0);
          done_cnt_a++;
        end
        if (bus_b.RAM_ren) begin
          check("b_addr", int'(bus_b.RAM_addr), 0);
          ren_b++;
        end
        if (bus_b.out_valid && bus_b.out_ready) begin
          check("b_data", int'(bus_b.out_data), 'h5A);
          xfer_b++;
        end
        if (bus_b.done) done_b++;
      end
    end
  end

  task automatic fill_ram(input bit rnd);
    for (int i = 0; i < N; i++) ram_a[i] = rnd ? 8'($urandom) : 8'(8'hA0 + i);
  endtask

  // Pulse start for one cycle; returns just after the sampling edge.
  task automatic start_dump(input bit accepted);
    @(posedge clk);
    #1;
    bus_a.start = 1'b1;
    if (accepted) begin
      for (int i = 0; i < N; i++) exp_q.push_back(ram_a[i]);
      issued_a   = 0;
      xfer_a     = 0;
      done_cnt_a = 0;
    end
    @(posedge clk);
    #1;
    bus_a.start = 1'b0;
  endtask

  // Counts cycles (1 = cycle after the sampling edge) until done.
  task automatic wait_done(output int done_cyc, output int first_valid, output int busy_cnt);
    done_cyc = 0; first_valid = 0; busy_cnt = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (bus_a.busy) busy_cnt++;
      if (bus_a.out_valid && first_valid == 0) first_valid = c;
      if (bus_a.done) begin done_cyc = c; break; end
    end
    #2;
    if (done_cyc == 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 300 cycles");
    end
    check("all_bytes_out", exp_q.size(), 0);
    check("reads_issued", issued_a, N);
    check("done_count", done_cnt_a, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ren"},   int'(bus_a.RAM_ren),   0);
    check({tag, "_addr"},  int'(bus_a.RAM_addr),  0);
    check({tag, "_valid"}, int'(bus_a.out_valid), 0);
    check({tag, "_data"},  int'(bus_a.out_data),  0);
    check({tag, "_busy"},  int'(bus_a.busy),      0);
    check({tag, "_done"},  int'(bus_a.done),      0);
  endtask

  initial begin
    int dc, fv, bc;
    bit reached;
    bus_a.start   = 1'b0;
    bus_b.start   = 1'b0;
    bus_b.out_ready = 1'b1;
    bus_a.RAM_out = '0;
    bus_b.RAM_out = '0;
    ram_b = 8'h5A;
    fill_ram(0);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Full-throughput dump: timing from the sampling edge
    ready_mode = 0;
    start_dump(1);
    wait_done(dc, fv, bc);
    check("first_valid_cycle", fv, 3);
    check("done_cycle", dc, 11);
    check("busy_cycles", bc, 11);
    @(negedge clk);
    check("done_single_pulse", int'(bus_a.done), 0);
    check("busy_after_done", int'(bus_a.busy), 0);
    check("addr_back_to_0", int'(bus_a.RAM_addr), 0);

    // Backpressure pattern 1,0,0
    ready_mode = 1;
    start_dump(1);
    wait_done(dc, fv, bc);

    // Long stall: only two reads may be issued
    ready_mode = 3;
    start_dump(1);
    repeat (20) @(negedge clk);
    #2;
    check("stall_reads", issued_a, 2);
    ready_mode = 0;
    wait_done(dc, fv, bc);

    // Mid-dump start ignored; restart right after done
    ready_mode = 0;
    start_dump(1);
    repeat (3) @(negedge clk);
    start_dump(0);
    wait_done(dc, fv, bc);
    start_dump(1);
    wait_done(dc, fv, bc);

    // Reset after 4 transfers, then a clean dump
    ready_mode = 1;
    start_dump(1);
    reached = 0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      #2;
      if (xfer_a >= 4) begin reached = 1; break; end
    end
    check("reached_4_bytes", int'(reached), 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    @(negedge clk);
    rst = 1'b0;
    ready_mode = 0;
    start_dump(1);
    wait_done(dc, fv, bc);

    // Randomized contents and backpressure
    for (int k = 0; k < 4; k++) begin
      fill_ram(1);
      ready_mode = 2;
      start_dump(1);
      wait_done(dc, fv, bc);
    end
    ready_mode = 0;

    // Single-byte instance
    @(posedge clk);
    #1;
    bus_b.start = 1'b1;
    @(posedge clk);
    #1;
    bus_b.start = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    check("b_ren_cycles", ren_b, 1);
    check("b_transfers", xfer_b, 1);
    check("b_done_count", done_b, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
